music_player_ctrl: RTL and testbench
====================================

// Module: music_player_ctrl
// PURPOSE
//   Navigation/playback controller directly downstream of the keyboard control stage.
//   Consumes its one-cycle key pulses (up/down/enter/esc/fast_forward/back_forward)
//   and a beat-rate tick. Runs the MENU/PLAY/PAUSE state machine, the highlighted
//   menu entry, the playing song and the beat address that drives the song ROM and
//   the tone generator.
// PARAMETERS
//   NUM_SONGS  4    number of songs in ROM (>=2); SONG_W = $clog2(NUM_SONGS)
//   SONG_LEN   512  beats per song (>=2); BEAT_W = $clog2(SONG_LEN)
//   SKIP       16   beats moved per fast_forward/back_forward pulse (1..SONG_LEN-1)
// PORTS
//   clk           in   1       system clock
//   rst           in   1       asynchronous reset, active-high
//   beat_tick     in   1       1-cycle pulse per beat (from beat divider)
//   up            in   1       1-cycle key pulse
//   down          in   1       1-cycle key pulse
//   enter         in   1       1-cycle key pulse
//   esc           in   1       1-cycle key pulse
//   fast_forward  in   1       1-cycle key pulse
//   back_forward  in   1       1-cycle key pulse
//   state         out  2       MENU=2'd0, PLAY=2'd1, PAUSE=2'd2 (2'd3 unused)
//   menu_sel      out  SONG_W  highlighted menu entry
//   song_id       out  SONG_W  song being played/paused
//   beat_addr     out  BEAT_W  current beat in song_id
//   playing       out  1       1 only in PLAY (audio enable)
//   song_done     out  1       1-cycle pulse when last beat of a song completes
// BEHAVIOUR
//   - All outputs registered; an input pulse in cycle N is visible on outputs in N+1.
//   - Reset (async): state=MENU, menu_sel=0, song_id=0, beat_addr=0, playing=0, song_done=0.
//   - Same-cycle pulses: only the highest-priority key acts.
//     Priority: esc > enter > fast_forward > back_forward > up > down.
//   - MENU:
//       up:   menu_sel-1, wrapping 0 -> NUM_SONGS-1.
//       down: menu_sel+1, wrapping NUM_SONGS-1 -> 0.
//       enter: song_id<=menu_sel, beat_addr<=0, go to PLAY.
//       esc, fast_forward, back_forward and beat_tick are ignored.
//   - PLAY:
//       beat_tick: beat_addr+1.
//       beat_tick at beat_addr==SONG_LEN-1: song_done=1 for one cycle, beat_addr<=0,
//         song_id and menu_sel <= (song_id+1) mod NUM_SONGS, stay in PLAY.
//       enter: go to PAUSE.
//       esc: go to MENU, beat_addr<=0, menu_sel<=song_id.
//       up and down are ignored.
//   - PAUSE:
//       enter: go to PLAY. esc: same as in PLAY. beat_tick is ignored.
//   - Skips (PLAY and PAUSE):
//       fast_forward: beat_addr=min(beat_addr+SKIP, SONG_LEN-1); never raises song_done.
//       back_forward: beat_addr=max(beat_addr-SKIP, 0).
//       Compute in BEAT_W+1 bits so nothing wraps.
//   - A beat_tick in the same cycle as an acting esc/enter/fast_forward/back_forward
//     is dropped. It is not queued.
//   - playing = (state==PLAY), registered with state.
//   - Illegal state 2'd3 recovers to MENU on the next clock with beat_addr<=0.
//   - Reset asserted mid-song returns to the reset values at once; a key or tick
//     pulse coincident with reset release is lost.
// STRUCTURE
//   - music_pkg: state encodings ST_MENU/ST_PLAY/ST_PAUSE and the width helper
//     functions. The keyboard control stage and the audio stage share the package.
//   - Sub-module player_beat_cnt holds beat_addr.
//     Inputs: clr, tick, ff, bf. Outputs: beat_addr, wrap.
//     It implements increment, saturating skip and wrap detection.
//   - The FSM and the menu/song registers stay in this module.
// TESTING  (NUM_SONGS=4, SONG_LEN=512, SKIP=16)
//   1. Reset, then up x1 in MENU -> menu_sel=3. Then down x2 -> menu_sel=1.
//      state stays 0 and playing stays 0 throughout.
//   2. menu_sel=2, enter -> next cycle state=1, song_id=2, beat_addr=0, playing=1.
//      Then 5 beat_ticks -> beat_addr=5.
//   3. PLAY at beat_addr=8, back_forward -> 0. At 500, fast_forward -> 511.
//      A further fast_forward -> 511 with no song_done.
//   4. PLAY song_id=3 at beat_addr=511, beat_tick -> song_done pulses 1 cycle,
//      beat_addr=0, song_id=0, menu_sel=0, state=1.
//   5. PLAY, enter -> PAUSE (playing=0). Ticks leave beat_addr unchanged;
//      fast_forward still adds 16. enter -> PLAY. esc -> MENU, beat_addr=0,
//      menu_sel=song_id.
//   6. Same cycle: esc+enter in PLAY -> MENU. fast_forward+beat_tick at 100 -> 116.
//      rst pulse mid-PLAY -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/music_pkg.sv
// Shared encodings and width helpers for the keyboard, player and audio stages.
package music_pkg;

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/player_beat_cnt.sv
// Beat address counter: tick increment with wrap detect, saturating skips, clear.
module player_beat_cnt
  import music_pkg::*;
#(
  parameter  int SONG_LEN = 512,
  parameter  int SKIP     = 16,
  localparam int BEAT_W   = idx_w(SONG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              tick,
  input  logic              ff,
  input  logic              bf,
  output logic [BEAT_W-1:0] beat_addr,
  output logic              wrap
);

  localparam logic [BEAT_W:0]   LAST_X = (BEAT_W+1)'(SONG_LEN - 1);
  localparam logic [BEAT_W:0]   SKIP_X = (BEAT_W+1)'(SKIP);
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(SONG_LEN - 1);
  localparam logic [BEAT_W-1:0] SKIP_B = BEAT_W'(SKIP);

  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W:0]   w_fwd;
  logic [BEAT_W-1:0] w_bwd;

  // One extra bit on the forward sum so the saturation compare sees the carry.
  assign w_fwd = {1'b0, r_beat} + SKIP_X;
  assign w_bwd = r_beat - SKIP_B;
  assign wrap  = tick && !clr && !ff && !bf && (r_beat == LAST_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else if (clr) begin
      r_beat <= '0;
    end else if (ff) begin
      r_beat <= (w_fwd > LAST_X) ? LAST_B : w_fwd[BEAT_W-1:0];
    end else if (bf) begin
      r_beat <= (r_beat < SKIP_B) ? '0 : w_bwd;
    end else if (tick) begin
      r_beat <= wrap ? '0 : r_beat + 1'b1;
    end
  end

  assign beat_addr = r_beat;

endmodule

// File: rtl/music_player_ctrl.sv
// Menu/play/pause navigation FSM with menu selection, current song and beat address.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter  int NUM_SONGS = 4,
  parameter  int SONG_LEN  = 512,
  parameter  int SKIP      = 16,
  localparam int SONG_W    = idx_w(NUM_SONGS),
  localparam int BEAT_W    = idx_w(SONG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_tick,
  input  logic              up,
  input  logic              down,
  input  logic              enter,
  input  logic              esc,
  input  logic              fast_forward,
  input  logic              back_forward,
  output logic [1:0]        state,
  output logic [SONG_W-1:0] menu_sel,
  output logic [SONG_W-1:0] song_id,
  output logic [BEAT_W-1:0] beat_addr,
  output logic              playing,
  output logic              song_done
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  state_t            r_state;
  logic [SONG_W-1:0] r_menu_sel;
  logic [SONG_W-1:0] r_song_id;
  logic              r_playing;
  logic              r_song_done;

  logic              w_in_menu;
  logic              w_in_play;
  logic              w_run;
  logic              w_illegal;
  logic              w_clr;
  logic              w_ff;
  logic              w_bf;
  logic              w_tick;
  logic              w_wrap;
  logic [SONG_W-1:0] w_next_song;

  assign w_in_menu = (r_state == ST_MENU);
  assign w_in_play = (r_state == ST_PLAY);
  assign w_run     = w_in_play || (r_state == ST_PAUSE);
  assign w_illegal = !w_in_menu && !w_run;

  // Key priority esc > enter > ff > bf; a tick only survives when none of them acts.
  assign w_clr  = (w_in_menu && !esc && enter) || (w_run && esc) || w_illegal;
  assign w_ff   = w_run && !esc && !enter && fast_forward;
  assign w_bf   = w_run && !esc && !enter && !fast_forward && back_forward;
  assign w_tick = w_in_play && beat_tick && !esc && !enter && !fast_forward && !back_forward;

  assign w_next_song = (r_song_id == LAST_SONG) ? '0 : r_song_id + 1'b1;

  player_beat_cnt #(
    .SONG_LEN (SONG_LEN),
    .SKIP     (SKIP)
  ) u_beat_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clr),
    .tick      (w_tick),
    .ff        (w_ff),
    .bf        (w_bf),
    .beat_addr (beat_addr),
    .wrap      (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_MENU;
      r_menu_sel  <= '0;
      r_song_id   <= '0;
      r_playing   <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_song_done <= 1'b0;
      case (r_state)
        ST_MENU: begin
          // A higher-priority key that MENU ignores still masks up/down.
          if (esc) begin
          end else if (enter) begin
            r_song_id <= r_menu_sel;
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end else if (fast_forward || back_forward) begin
          end else if (up) begin
            r_menu_sel <= (r_menu_sel == '0) ? LAST_SONG : r_menu_sel - 1'b1;
          end else if (down) begin
            r_menu_sel <= (r_menu_sel == LAST_SONG) ? '0 : r_menu_sel + 1'b1;
          end
        end
        ST_PLAY: begin
          if (esc) begin
            r_state    <= ST_MENU;
            r_playing  <= 1'b0;
            r_menu_sel <= r_song_id;
          end else if (enter) begin
            r_state   <= ST_PAUSE;
            r_playing <= 1'b0;
          end else if (w_wrap) begin
            r_song_done <= 1'b1;
            r_song_id   <= w_next_song;
            r_menu_sel  <= w_next_song;
          end
        end
        ST_PAUSE: begin
          if (esc) begin
            r_state    <= ST_MENU;
            r_playing  <= 1'b0;
            r_menu_sel <= r_song_id;
          end else if (enter) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_MENU;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign menu_sel  = r_menu_sel;
  assign song_id   = r_song_id;
  assign playing   = r_playing;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Scoreboard bench for music_player_ctrl: directed key/tick vectors, queued expectations.
module tb_music_player_ctrl;

  localparam logic [6:0] K_NONE = 7'b0000000;
  localparam logic [6:0] K_TICK = 7'b1000000;
  localparam logic [6:0] K_UP   = 7'b0100000;
  localparam logic [6:0] K_DOWN = 7'b0010000;
  localparam logic [6:0] K_ENT  = 7'b0001000;
  localparam logic [6:0] K_ESC  = 7'b0000100;
  localparam logic [6:0] K_FF   = 7'b0000010;
  localparam logic [6:0] K_BF   = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       beat_tick = 1'b0, up = 1'b0, down = 1'b0, enter = 1'b0;
  logic       esc = 1'b0, fast_forward = 1'b0, back_forward = 1'b0;
  logic [1:0] state;
  logic [1:0] menu_sel, song_id;
  logic [8:0] beat_addr;
  logic       playing, song_done;

  typedef struct {
    int         due;
    string      name;
    logic [1:0] st;
    logic [1:0] menu;
    logic [1:0] song;
    logic [8:0] beat;
    logic       play;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] e_st = 0, e_menu = 0, e_song = 0;
  logic [8:0] e_beat = 0;
  logic       e_play = 0, e_done = 0;

  music_player_ctrl #(.NUM_SONGS(4), .SONG_LEN(512), .SKIP(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .beat_tick    (beat_tick),
    .up           (up),
    .down         (down),
    .enter        (enter),
    .esc          (esc),
    .fast_forward (fast_forward),
    .back_forward (back_forward),
    .state        (state),
    .menu_sel     (menu_sel),
    .song_id      (song_id),
    .beat_addr    (beat_addr),
    .playing      (playing),
    .song_done    (song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input exp_t e);
    total++;
    if (state !== e.st || menu_sel !== e.menu || song_id !== e.song ||
        beat_addr !== e.beat || playing !== e.play || song_done !== e.done) begin
      bad++;
      $display("FAIL %s: got st=%0d menu=%0d song=%0d beat=%0d play=%0d done=%0d want st=%0d menu=%0d song=%0d beat=%0d play=%0d done=%0d",
               e.name, state, menu_sel, song_id, beat_addr, playing, song_done,
               e.st, e.menu, e.song, e.beat, e.play, e.done);
    end
  endtask

  function automatic exp_t snap(input string nm, input int due);
    exp_t e;
    e.due = due; e.name = nm; e.st = e_st; e.menu = e_menu; e.song = e_song;
    e.beat = e_beat; e.play = e_play; e.done = e_done;
    return e;
  endfunction

  // Monitor: compare each expectation once the clock edge it describes has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      cmp(q.pop_front());
    end
  end

  task automatic step(input logic [6:0] k, input string nm);
    @(negedge clk);
    {beat_tick, up, down, enter, esc, fast_forward, back_forward} = k;
    q.push_back(snap(nm, cyc + 1));
    e_done = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    {beat_tick, up, down, enter, esc, fast_forward, back_forward} = K_NONE;
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic clear_exp();
    e_st = 0; e_menu = 0; e_song = 0; e_beat = 0; e_play = 0; e_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp(snap("reset", 0));
    @(negedge clk);
    rst = 1'b0;

    step(K_NONE, "idle_after_reset");
    e_menu = 3; step(K_UP, "up_wrap");
    e_menu = 0; step(K_DOWN, "down_wrap");
    e_menu = 1; step(K_DOWN, "down");
    e_menu = 2; step(K_DOWN, "down2");
    step(K_TICK, "menu_tick_ign");
    step(K_ESC | K_FF | K_BF, "menu_esc_ff_bf_ign");

    e_st = 1; e_song = 2; e_beat = 0; e_play = 1; step(K_ENT, "enter_play");
    for (int i = 1; i <= 5; i++) begin e_beat = 9'(i); step(K_TICK, "tick"); end
    step(K_UP | K_DOWN, "play_updown_ign");
    for (int i = 6; i <= 8; i++) begin e_beat = 9'(i); step(K_TICK, "tick_to8"); end
    e_beat = 0; step(K_BF, "bf_to0");
    step(K_BF, "bf_at0");
    for (int i = 1; i <= 31; i++) begin e_beat = 9'(16 * i); step(K_FF, "ff_to496"); end
    for (int i = 497; i <= 500; i++) begin e_beat = 9'(i); step(K_TICK, "tick_to500"); end
    e_beat = 511; step(K_FF, "ff_sat");
    step(K_FF, "ff_sat_again");

    e_done = 1; e_beat = 0; e_song = 3; e_menu = 3; step(K_TICK, "wrap_song2");
    step(K_NONE, "done_clear");
    for (int i = 1; i <= 31; i++) begin e_beat = 9'(16 * i); step(K_FF, "ff_song3"); end
    e_beat = 511; step(K_FF, "ff_song3_sat");
    e_done = 1; e_beat = 0; e_song = 0; e_menu = 0; step(K_TICK, "wrap_last_song");
    for (int i = 1; i <= 3; i++) begin e_beat = 9'(i); step(K_TICK, "tick_song0"); end

    e_st = 2; e_play = 0; step(K_ENT, "pause");
    step(K_TICK, "pause_tick_ign");
    e_beat = 19; step(K_FF, "pause_ff");
    e_beat = 3; step(K_BF, "pause_bf");
    e_st = 1; e_play = 1; step(K_ENT, "resume");
    e_beat = 4; step(K_TICK, "resume_tick");
    e_st = 0; e_play = 0; e_beat = 0; e_menu = 0; step(K_ESC, "esc_menu");

    e_menu = 1; step(K_DOWN, "menu_down");
    e_st = 1; e_play = 1; e_song = 1; step(K_ENT, "enter_song1");
    e_st = 0; e_play = 0; e_beat = 0; step(K_ESC | K_ENT, "esc_over_enter");
    e_st = 1; e_play = 1; step(K_ENT, "replay_song1");
    for (int i = 1; i <= 6; i++) begin e_beat = 9'(16 * i); step(K_FF, "ff_to96"); end
    for (int i = 97; i <= 100; i++) begin e_beat = 9'(i); step(K_TICK, "tick_to100"); end
    e_beat = 116; step(K_FF | K_TICK, "ff_drops_tick");
    e_beat = 100; step(K_BF | K_TICK, "bf_drops_tick");
    e_st = 2; e_play = 0; step(K_ENT | K_TICK, "enter_drops_tick");
    e_st = 1; e_play = 1; step(K_ENT | K_FF, "enter_over_ff");
    e_beat = 101; step(K_UP | K_TICK, "up_ign_tick_acts");
    e_beat = 117; step(K_FF | K_BF, "ff_over_bf");
    e_st = 0; e_play = 0; e_beat = 0; e_menu = 1; step(K_ESC | K_TICK, "esc_drops_tick");
    step(K_FF | K_UP, "menu_ff_masks_up");
    e_menu = 0; step(K_UP | K_DOWN, "up_over_down");

    e_st = 1; e_play = 1; e_song = 0; step(K_ENT, "enter_song0");
    for (int i = 1; i <= 3; i++) begin e_beat = 9'(i); step(K_TICK, "tick_pre_rst"); end
    drain();

    #2 rst = 1'b1;
    #1;
    clear_exp();
    cmp(snap("async_rst", 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(K_NONE, "post_rst_idle");
    e_menu = 3; step(K_UP, "post_rst_up");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
